// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// FETCH_PERF_CNT_EN (optional build macro) is consumed by if_fetch_unit.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;

endpackage

// File: rtl/pc_register.sv
// Program counter flop: synchronous active-low reset, branch load and sequential increment.
// Load takes priority over increment; the incremented value wraps modulo 2^PC_W.
module pc_register
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [PC_W-1:0] loadValue_i,
  input  logic            incr_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pcPlusInc_o
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  assign pcPlusInc_o = pc_q + PC_W'(PC_INC);
  assign pc_o        = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = loadValue_i;
    end else if (incr_i) begin
      pc_d = pcPlusInc_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem request/ack handshake and IF/ID write/flush control.
// Define FETCH_PERF_CNT_EN to add saturating stall-cycle and flush-pulse counters.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] Instruction_out,
  output logic [PC_W-1:0]    PC_out,
  output logic               ifid_enable,
  output logic               ifid_flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  fetch_state_e        state_q, state_d;
  logic [INSTR_W-1:0]  holdInstr_q, holdInstr_d;
  logic [PC_W-1:0]     drainAddr_q, drainAddr_d;
  logic [INSTR_W-1:0]  instrOut_q;
  logic [PC_W-1:0]     pcOut_q;
  logic                ifidEnable_q;
  logic                ifidFlush_q, ifidFlush_d;

  logic                pcLoad, pcIncr, writeIfid;
  logic [INSTR_W-1:0]  writeData;
  logic [PC_W-1:0]     pc, pcPlusInc, branchAddr;

  assign branchAddr = branch_target & ~PC_W'(3);

  pc_register #(
    .PC_W    (PC_W),
    .RESET_PC(RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pcLoad),
    .loadValue_i(branchAddr),
    .incr_i     (pcIncr),
    .pc_o       (pc),
    .pcPlusInc_o(pcPlusInc)
  );

  always_comb begin
    state_d     = state_q;
    holdInstr_d = holdInstr_q;
    drainAddr_d = drainAddr_q;
    ifidFlush_d = 1'b0;
    pcLoad      = 1'b0;
    pcIncr      = 1'b0;
    writeIfid   = 1'b0;
    writeData   = imem_rdata;
    imem_req    = 1'b0;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (branch_taken) begin
          pcLoad      = 1'b1;
          ifidFlush_d = 1'b1;
        end
      end
      REQ: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pcLoad      = 1'b1;
          ifidFlush_d = 1'b1;
          // The in-flight request cannot be cancelled, so its address is kept for the drain.
          if (!imem_ack) begin
            drainAddr_d = pc;
            state_d     = DRAIN;
          end
        end else if (imem_ack) begin
          if (stall) begin
            holdInstr_d = imem_rdata;
            state_d     = HOLD;
          end else begin
            writeIfid = 1'b1;
            pcIncr    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pcLoad      = 1'b1;
          ifidFlush_d = 1'b1;
          state_d     = REQ;
        end else if (!stall) begin
          writeIfid = 1'b1;
          writeData = holdInstr_q;
          pcIncr    = 1'b1;
          state_d   = REQ;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        if (branch_taken) begin
          pcLoad      = 1'b1;
          ifidFlush_d = 1'b1;
        end
        if (imem_ack) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_addr = pc;
    if (state_q == DRAIN) begin
      imem_addr = drainAddr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      holdInstr_q  <= INSTR_W'(NOP_INSTR);
      drainAddr_q  <= RESET_PC;
      instrOut_q   <= INSTR_W'(NOP_INSTR);
      pcOut_q      <= '0;
      ifidEnable_q <= 1'b0;
      ifidFlush_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      holdInstr_q  <= holdInstr_d;
      drainAddr_q  <= drainAddr_d;
      ifidEnable_q <= writeIfid;
      ifidFlush_q  <= ifidFlush_d;
      if (writeIfid) begin
        instrOut_q <= writeData;
        pcOut_q    <= pcPlusInc;
      end
    end
  end

  assign Instruction_out = instrOut_q;
  assign PC_out          = pcOut_q;
  assign ifid_enable     = ifidEnable_q;
  assign ifid_flush      = ifidFlush_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perfStallCnt_q;
  logic [31:0] perfFlushCnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perfStallCnt_q <= '0;
      perfFlushCnt_q <= '0;
    end else begin
      if (stall && (state_q == REQ || state_q == HOLD) && perfStallCnt_q != '1) begin
        perfStallCnt_q <= perfStallCnt_q + 32'd1;
      end
      if (ifidFlush_q && perfFlushCnt_q != '1) begin
        perfFlushCnt_q <= perfFlushCnt_q + 32'd1;
      end
    end
  end

  assign perf_stall_cnt = perfStallCnt_q;
  assign perf_flush_cnt = perfFlushCnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios pinned to literal values, then random traffic
// compared each cycle against a transaction-level model of the fetch rules.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        resetN;
  logic        stallIn;
  logic        branchIn;
  logic [31:0] targetIn;
  logic        ackIn;
  logic [31:0] rdataIn;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instruction_out;
  logic [31:0] PC_out;
  logic        ifid_enable;
  logic        ifid_flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int compared;
  int mismatched;
  bit checkEn;

  // Model of the fetch rules: which word is still owed to IF/ID, whether an abandoned request is in flight
  bit          mBoot;
  bit          mHeld;
  logic [31:0] mHeldWord;
  bit          mStale;
  logic [31:0] mStaleAddr;
  logic [31:0] mPc;
  bit          eEnable;
  bit          eFlush;
  logic [31:0] eInstr;
  logic [31:0] ePcOut;

  always #5 clk = ~clk;

  if_fetch_unit #(
    .PC_W    (32),
    .INSTR_W (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (resetN),
    .stall          (stallIn),
    .branch_taken   (branchIn),
    .branch_target  (targetIn),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (ackIn),
    .imem_rdata     (rdataIn),
    .Instruction_out(Instruction_out),
    .PC_out         (PC_out),
    .ifid_enable    (ifid_enable),
    .ifid_flush     (ifid_flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h at %0t", name, actual, required, $time);
    end
  endtask

  // Inputs change on the falling edge so the DUT and the model both see them settled at the rising edge.
  task automatic applyStimulus(input bit rst, input bit st, input bit br, input logic [31:0] tgt,
                               input bit ack, input logic [31:0] rd, input bit gateAck);
    @(negedge clk);
    resetN   = rst;
    stallIn  = st;
    branchIn = br;
    targetIn = tgt;
    ackIn    = gateAck ? (ack && !mBoot && !mHeld) : ack;
    rdataIn  = rd;
  endtask

  always @(posedge clk) begin
    logic [31:0] tgt;
    bit          nEnable;
    if (!resetN) begin
      mBoot   = 1'b1;
      mHeld   = 1'b0;
      mStale  = 1'b0;
      mPc     = 32'h0;
      eEnable = 1'b0;
      eFlush  = 1'b0;
      eInstr  = 32'h0;
      ePcOut  = 32'h0;
    end else begin
      tgt     = {targetIn[31:2], 2'b00};
      nEnable = 1'b0;
      if (mBoot) begin
        mBoot = 1'b0;
        if (branchIn) mPc = tgt;
      end else if (mHeld) begin
        if (branchIn) begin
          mHeld = 1'b0;
          mPc   = tgt;
        end else if (!stallIn) begin
          nEnable = 1'b1;
          eInstr  = mHeldWord;
          ePcOut  = mPc + 32'd4;
          mPc     = mPc + 32'd4;
          mHeld   = 1'b0;
        end
      end else if (mStale) begin
        if (ackIn) mStale = 1'b0;
        if (branchIn) mPc = tgt;
      end else if (branchIn) begin
        if (!ackIn) begin
          mStale     = 1'b1;
          mStaleAddr = mPc;
        end
        mPc = tgt;
      end else if (ackIn) begin
        if (stallIn) begin
          mHeld     = 1'b1;
          mHeldWord = rdataIn;
        end else begin
          nEnable = 1'b1;
          eInstr  = rdataIn;
          ePcOut  = mPc + 32'd4;
          mPc     = mPc + 32'd4;
        end
      end
      eEnable = nEnable;
      eFlush  = branchIn;
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("imem_req", 32'(imem_req), 32'(!mBoot && !mHeld));
      if (!mBoot && !mHeld) begin
        checkOutput("imem_addr", imem_addr, mStale ? mStaleAddr : mPc);
      end
      checkOutput("ifid_enable", 32'(ifid_enable), 32'(eEnable));
      checkOutput("ifid_flush", 32'(ifid_flush), 32'(eFlush));
      checkOutput("Instruction_out", Instruction_out, eInstr);
      checkOutput("PC_out", PC_out, ePcOut);
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    checkEn    = 1'b0;
    resetN     = 1'b0;
    stallIn    = 1'b0;
    branchIn   = 1'b0;
    targetIn   = 32'h0;
    ackIn      = 1'b0;
    rdataIn    = 32'h0;
    mBoot      = 1'b1;
    mHeld      = 1'b0;
    mStale     = 1'b0;

    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    checkEn = 1'b1;

    // Reset state
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("rst_req", 32'(imem_req), 32'h0);
    checkOutput("rst_enable", 32'(ifid_enable), 32'h0);
    checkOutput("rst_flush", 32'(ifid_flush), 32'h0);
    checkOutput("rst_instr", Instruction_out, 32'h0);
    checkOutput("rst_pcout", PC_out, 32'h0);

    // Zero-wait acks deliver one instruction per cycle
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h2008_0001, 0);
    checkOutput("t1_req", 32'(imem_req), 32'h1);
    checkOutput("t1_addr0", imem_addr, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h2009_0002, 0);
    checkOutput("t1_instr0", Instruction_out, 32'h2008_0001);
    checkOutput("t1_pcout0", PC_out, 32'h4);
    checkOutput("t1_en0", 32'(ifid_enable), 32'h1);
    checkOutput("t1_addr1", imem_addr, 32'h4);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t1_instr1", Instruction_out, 32'h2009_0002);
    checkOutput("t1_pcout1", PC_out, 32'h8);
    checkOutput("t1_en1", 32'(ifid_enable), 32'h1);

    // Reset while a request is outstanding, ack arrives the cycle after
    applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hDEAD_BEEF, 0);
    checkOutput("t6_req", 32'(imem_req), 32'h0);
    checkOutput("t6_instr", Instruction_out, 32'h0);
    checkOutput("t6_pcout", PC_out, 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t6_req2", 32'(imem_req), 32'h1);
    checkOutput("t6_addr", imem_addr, 32'h0);
    checkOutput("t6_en", 32'(ifid_enable), 32'h0);

    // Stall held for three cycles on the ack at pc=4
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h2008_0001, 0);
    applyStimulus(1, 1, 0, 32'h0, 1, 32'hFFFF_FFFF, 0);
    checkOutput("t2_addr", imem_addr, 32'h4);
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t2_req_off", 32'(imem_req), 32'h0);
    checkOutput("t2_en_off1", 32'(ifid_enable), 32'h0);
    applyStimulus(1, 1, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t2_en_off2", 32'(ifid_enable), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t2_en_off3", 32'(ifid_enable), 32'h0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t2_en_rel", 32'(ifid_enable), 32'h1);
    checkOutput("t2_instr", Instruction_out, 32'hFFFF_FFFF);
    checkOutput("t2_pcout", PC_out, 32'h8);

    // Redirect to 0x40 while the request at 0x8 waits two cycles for its ack
    applyStimulus(1, 0, 1, 32'h40, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t3_flush", 32'(ifid_flush), 32'h1);
    checkOutput("t3_en", 32'(ifid_enable), 32'h0);
    checkOutput("t3_hold_addr", imem_addr, 32'h8);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hBADB_AD00, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'h1234_5678, 0);
    checkOutput("t3_stale_en", 32'(ifid_enable), 32'h0);
    checkOutput("t3_new_addr", imem_addr, 32'h40);

    // Branch and stall together with the ack: branch wins
    applyStimulus(1, 1, 1, 32'h80, 1, 32'h5555_5555, 0);
    checkOutput("t3_instr", Instruction_out, 32'h1234_5678);
    checkOutput("t3_pcout", PC_out, 32'h44);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t4_flush", 32'(ifid_flush), 32'h1);
    checkOutput("t4_en", 32'(ifid_enable), 32'h0);
    checkOutput("t4_addr", imem_addr, 32'h80);

    // PC wrap at the top of the address space (target low bits are masked)
    applyStimulus(1, 0, 1, 32'hFFFF_FFFF, 1, 32'h0BAD_0BAD, 0);
    applyStimulus(1, 0, 0, 32'h0, 1, 32'hCAFE_F00D, 0);
    checkOutput("t5_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    checkOutput("t5_pcout", PC_out, 32'h0);
    checkOutput("t5_instr", Instruction_out, 32'hCAFE_F00D);
    checkOutput("t5_next_addr", imem_addr, 32'h0);

    // Random traffic; acks are only offered while the model expects a live request
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 249) != 0),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 11) == 0),
                    $urandom(),
                    ($urandom_range(0, 1) == 1),
                    $urandom(),
                    1);
    end
    applyStimulus(1, 0, 0, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    checkEn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
